// File: rtl/perf_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : perf_pkt_gen
// Purpose  : Timestamped descriptor generator for the perf datapath. Emits
//            cfg_pkt_count descriptors (0 = unlimited) on a valid/ready
//            channel. Flow classes are taken round-robin from
//            cfg_class_mask. Each descriptor carries the timestamp sampled
//            on the edge where its tvalid became or stayed asserted.
// Ports    : clk, rst (async, active-high)
//            enable, cfg_gap, cfg_pkt_count, cfg_class_mask : run control
//            timestamp                                      : time base
//            m_tx_axis_tvalid/tready, m_tx_axis_ts,
//            m_tx_flow_class, m_tx_seq                      : descriptor out
//            sent_count, busy, done                         : status
// Options  : `define PERF_PKT_GEN_JITTER_EN adds an LFSR-based random
//            extension of the inter-packet gap.
// Revision : 1.0 - initial release
// ============================================================================
module perf_pkt_gen #(
    parameter int TS_WIDTH    = 64,
    parameter int CLASS_WIDTH = 5,
    parameter int NUM_CLASS   = 5,
    parameter int GAP_WIDTH   = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [GAP_WIDTH-1:0]   cfg_gap,
    input  logic [CNT_WIDTH-1:0]   cfg_pkt_count,
    input  logic [NUM_CLASS-1:0]   cfg_class_mask,
    input  logic [TS_WIDTH-1:0]    timestamp,
    output logic                   m_tx_axis_tvalid,
    input  logic                   m_tx_axis_tready,
    output logic [TS_WIDTH-1:0]    m_tx_axis_ts,
    output logic [CLASS_WIDTH-1:0] m_tx_flow_class,
    output logic [CNT_WIDTH-1:0]   m_tx_seq,
    output logic [CNT_WIDTH-1:0]   sent_count,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_send = 2'd1;
    localparam logic [1:0] c_st_gap  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]             r_state;
    logic [GAP_WIDTH-1:0]   r_gap;
    logic [CNT_WIDTH-1:0]   r_pkt_count;
    logic [NUM_CLASS-1:0]   r_mask;
    logic [CLASS_WIDTH-1:0] r_class;
    logic [TS_WIDTH-1:0]    r_ts;
    logic [CNT_WIDTH-1:0]   r_seq;
    logic [CNT_WIDTH-1:0]   r_sent;
    logic [GAP_WIDTH-1:0]   r_gap_cnt;

    logic [CNT_WIDTH-1:0]   w_sent_next;
    logic [GAP_WIDTH-1:0]   w_eff_gap;

    // Lowest set bit of the mask; 0 when the mask is empty.
    function automatic logic [CLASS_WIDTH-1:0] f_lowest_class(input logic [NUM_CLASS-1:0] mask);
        logic [CLASS_WIDTH-1:0] result;
        result = '0;
        for (int i = NUM_CLASS - 1; i >= 0; i--) begin
            if (mask[i]) result = CLASS_WIDTH'(i);
        end
        return result;
    endfunction

    // Next set bit strictly above cur, wrapping to the lowest set bit.
    function automatic logic [CLASS_WIDTH-1:0] f_next_class(input logic [NUM_CLASS-1:0] mask,
                                                            input logic [CLASS_WIDTH-1:0] cur);
        logic [CLASS_WIDTH-1:0] result;
        logic                   found;
        result = f_lowest_class(mask);
        found  = 1'b0;
        for (int i = 0; i < NUM_CLASS; i++) begin
            if (!found && mask[i] && (i > int'(cur))) begin
                result = CLASS_WIDTH'(i);
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    assign w_sent_next = r_sent + 1'b1;

`ifdef PERF_PKT_GEN_JITTER_EN
    logic [15:0]          r_lfsr;
    logic [15:0]          w_lfsr_next;
    logic [GAP_WIDTH:0]   w_gap_sum;

    // Right-shifting Fibonacci form of the x^16+x^14+x^13+x^11+1 polynomial.
    assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    // One extra bit of headroom so the sum can saturate instead of wrapping.
    assign w_gap_sum   = {1'b0, r_gap} + (GAP_WIDTH+1)'(r_lfsr[3:0]);
    assign w_eff_gap   = w_gap_sum[GAP_WIDTH] ? {GAP_WIDTH{1'b1}} : w_gap_sum[GAP_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else if (r_state == c_st_idle && enable && |cfg_class_mask) begin
            r_lfsr <= 16'hACE1;
        end else if (r_state == c_st_send && m_tx_axis_tready) begin
            r_lfsr <= w_lfsr_next;
        end
    end
`else
    assign w_eff_gap = r_gap;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_gap       <= '0;
            r_pkt_count <= '0;
            r_mask      <= '0;
            r_class     <= '0;
            r_ts        <= '0;
            r_seq       <= '0;
            r_sent      <= '0;
            r_gap_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (enable && |cfg_class_mask) begin
                        r_gap       <= cfg_gap;
                        r_pkt_count <= cfg_pkt_count;
                        r_mask      <= cfg_class_mask;
                        r_class     <= f_lowest_class(cfg_class_mask);
                        r_sent      <= '0;
                        r_seq       <= '0;
                        r_ts        <= timestamp;
                        r_state     <= c_st_send;
                    end
                end
                c_st_send: begin
                    // Descriptor fields are held until the handshake; enable
                    // is only consulted once the beat has been accepted.
                    if (m_tx_axis_tready) begin
                        r_sent  <= w_sent_next;
                        r_seq   <= r_seq + 1'b1;
                        r_class <= f_next_class(r_mask, r_class);
                        if (r_pkt_count != '0 && w_sent_next == r_pkt_count) begin
                            r_state <= c_st_done;
                        end else if (!enable) begin
                            r_state <= c_st_idle;
                        end else if (w_eff_gap == '0) begin
                            r_ts <= timestamp;
                        end else begin
                            r_gap_cnt <= w_eff_gap;
                            r_state   <= c_st_gap;
                        end
                    end
                end
                c_st_gap: begin
                    if (!enable) begin
                        r_state <= c_st_idle;
                    end else if (r_gap_cnt == GAP_WIDTH'(1)) begin
                        r_ts    <= timestamp;
                        r_state <= c_st_send;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    if (!enable) r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign m_tx_axis_tvalid = (r_state == c_st_send);
    assign m_tx_axis_ts     = r_ts;
    assign m_tx_flow_class  = r_class;
    assign m_tx_seq         = r_seq;
    assign sent_count       = r_sent;
    assign busy             = (r_state == c_st_send) || (r_state == c_st_gap);
    assign done             = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_perf_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_perf_pkt_gen
// Purpose  : Self-checking bench for perf_pkt_gen. A transaction-level model
//            predicts class order, sequence numbers, stamps and gap lengths
//            of each run; random ready back-pressure and random configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_perf_pkt_gen;

    localparam int TS_WIDTH    = 64;
    localparam int CLASS_WIDTH = 5;
    localparam int NUM_CLASS   = 5;
    localparam int GAP_WIDTH   = 16;
    localparam int CNT_WIDTH   = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   enable;
    logic [GAP_WIDTH-1:0]   cfg_gap;
    logic [CNT_WIDTH-1:0]   cfg_pkt_count;
    logic [NUM_CLASS-1:0]   cfg_class_mask;
    logic [TS_WIDTH-1:0]    timestamp;
    logic                   m_tx_axis_tvalid;
    logic                   m_tx_axis_tready;
    logic [TS_WIDTH-1:0]    m_tx_axis_ts;
    logic [CLASS_WIDTH-1:0] m_tx_flow_class;
    logic [CNT_WIDTH-1:0]   m_tx_seq;
    logic [CNT_WIDTH-1:0]   sent_count;
    logic                   busy;
    logic                   done;

    perf_pkt_gen #(
        .TS_WIDTH(TS_WIDTH), .CLASS_WIDTH(CLASS_WIDTH), .NUM_CLASS(NUM_CLASS),
        .GAP_WIDTH(GAP_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_gap(cfg_gap),
        .cfg_pkt_count(cfg_pkt_count), .cfg_class_mask(cfg_class_mask),
        .timestamp(timestamp), .m_tx_axis_tvalid(m_tx_axis_tvalid),
        .m_tx_axis_tready(m_tx_axis_tready), .m_tx_axis_ts(m_tx_axis_ts),
        .m_tx_flow_class(m_tx_flow_class), .m_tx_seq(m_tx_seq),
        .sent_count(sent_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model of the current run ----------------
    int          cls_list[$];
    int          k;            // handshakes so far in this run
    int          run_count;
    int          run_gap;
    logic [15:0] m_lfsr;
    logic [63:0] exp_stamp;
    bit          gap_track;
    int          idle;
    int          exp_gap;

    // Snapshot of the cycle before an edge.
    bit          pre_valid, hs, pre_en;
    logic [63:0] pre_ts, pre_time;
    logic [CLASS_WIDTH-1:0] pre_class;
    logic [CNT_WIDTH-1:0]   pre_seq;

    function automatic int model_gap();
        int g;
        int bitv;
        g = run_gap;
`ifdef PERF_PKT_GEN_JITTER_EN
        g = g + int'(m_lfsr[3:0]);
        if (g > (1 << GAP_WIDTH) - 1) g = (1 << GAP_WIDTH) - 1;
`endif
        bitv   = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | 16'(bitv << 15);
        return g;
    endfunction

    task automatic observe();
        int exp_cls;
        if (hs) begin
            exp_cls = (cls_list.size() > 0) ? cls_list[k % cls_list.size()] : 99;
            check("hs_class", 64'(pre_class), 64'(exp_cls));
            check("hs_seq", 64'(pre_seq), 64'(k));
            check("hs_ts", pre_ts, exp_stamp);
            k++;
            check("sent_count", 64'(sent_count), 64'(k));
            gap_track = pre_en && !(run_count != 0 && k == run_count);
            idle      = 0;
            exp_gap   = model_gap();
        end
        if (m_tx_axis_tvalid && (!pre_valid || hs)) begin
            check("stamp", m_tx_axis_ts, pre_time);
            exp_stamp = pre_time;
            if (gap_track) check("gap_len", 64'(idle), 64'(exp_gap));
            gap_track = 0;
        end else if (m_tx_axis_tvalid && pre_valid) begin
            check("stall_ts", m_tx_axis_ts, pre_ts);
            check("stall_class", 64'(m_tx_flow_class), 64'(pre_class));
            check("stall_seq", 64'(m_tx_seq), 64'(pre_seq));
        end else if (!m_tx_axis_tvalid && gap_track) begin
            idle++;
        end
    endtask

    task automatic step();
        pre_valid = m_tx_axis_tvalid;
        hs        = m_tx_axis_tvalid & m_tx_axis_tready;
        pre_ts    = m_tx_axis_ts;
        pre_class = m_tx_flow_class;
        pre_seq   = m_tx_seq;
        pre_time  = timestamp;
        pre_en    = enable;
        @(posedge clk);
        #1;
        observe();
        timestamp = timestamp + 1;
    endtask

    task automatic start_run(input logic [4:0] mask, input int count, input int gap);
        cfg_class_mask = mask;
        cfg_pkt_count  = CNT_WIDTH'(count);
        cfg_gap        = GAP_WIDTH'(gap);
        run_count      = count;
        run_gap        = gap;
        k              = 0;
        gap_track      = 0;
        m_lfsr         = 16'hACE1;
        cls_list.delete();
        for (int i = 0; i < NUM_CLASS; i++) if (mask[i]) cls_list.push_back(i);
        enable = 1'b1;
    endtask

    task automatic run_to_done(input int pct);
        int budget;
        budget = 0;
        while (k < run_count && budget < 1000) begin
            m_tx_axis_tready = (int'($urandom_range(0, 99)) < pct);
            step();
            budget++;
        end
        check("run_handshakes", 64'(k), 64'(run_count));
        check("done_set", 64'(done), 64'd1);
        check("done_tvalid", 64'(m_tx_axis_tvalid), 64'd0);
        check("done_busy", 64'(busy), 64'd0);
        check("done_sent", 64'(sent_count), 64'(run_count));
        step();
        check("done_hold", 64'(done), 64'd1);
        enable = 1'b0;
        m_tx_axis_tready = 1'b0;
        step();
        check("idle_done", 64'(done), 64'd0);
        check("idle_sent_kept", 64'(sent_count), 64'(run_count));
    endtask

    initial begin
        int budget;
        rst = 1'b1; enable = 1'b0; cfg_gap = '0; cfg_pkt_count = '0;
        cfg_class_mask = '0; timestamp = 64'h100; m_tx_axis_tready = 1'b0;
        gap_track = 0; k = 0; run_count = 0; run_gap = 0; m_lfsr = 16'hACE1;
        exp_stamp = '0; idle = 0; exp_gap = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(m_tx_axis_tvalid), 64'd0);
        check("rst_ts", m_tx_axis_ts, 64'd0);
        check("rst_class", 64'(m_tx_flow_class), 64'd0);
        check("rst_seq", 64'(m_tx_seq), 64'd0);
        check("rst_sent", 64'(sent_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        step();

        // Back-to-back, two classes alternating.
        start_run(5'b00101, 4, 0);
        run_to_done(100);
        // Fixed gap of two idle cycles.
        start_run(5'b01000, 3, 2);
        run_to_done(100);
        // Back-to-back, single class.
        start_run(5'b00001, 3, 0);
        run_to_done(100);

        // Five-cycle stall on the first descriptor.
        start_run(5'b10010, 2, 0);
        m_tx_axis_tready = 1'b0;
        repeat (6) step();
        check("stall_valid", 64'(m_tx_axis_tvalid), 64'd1);
        run_to_done(100);

        // Enable drops while a descriptor is stalled: it must still complete.
        start_run(5'b11010, 0, 1);
        m_tx_axis_tready = 1'b0;
        step();
        check("drop_valid_up", 64'(m_tx_axis_tvalid), 64'd1);
        enable = 1'b0;
        repeat (3) step();
        check("drop_valid_held", 64'(m_tx_axis_tvalid), 64'd1);
        m_tx_axis_tready = 1'b1;
        step();
        check("drop_sent", 64'(sent_count), 64'd1);
        check("drop_tvalid", 64'(m_tx_axis_tvalid), 64'd0);
        check("drop_busy", 64'(busy), 64'd0);
        check("drop_done", 64'(done), 64'd0);
        m_tx_axis_tready = 1'b0;
        step();

        // Empty mask never starts.
        start_run(5'b00000, 3, 0);
        m_tx_axis_tready = 1'b1;
        repeat (10) begin
            step();
            check("mask0_tvalid", 64'(m_tx_axis_tvalid), 64'd0);
            check("mask0_busy", 64'(busy), 64'd0);
        end
        enable = 1'b0;
        m_tx_axis_tready = 1'b0;
        step();

        // Randomized runs with random back-pressure.
        for (int r = 0; r < 12; r++) begin
            start_run(5'($urandom_range(1, 31)), int'($urandom_range(1, 6)),
                      int'($urandom_range(0, 3)));
            run_to_done(int'($urandom_range(40, 100)));
        end

        // Asynchronous reset in the middle of a gap.
        start_run(5'b00001, 0, 5);
        m_tx_axis_tready = 1'b1;
        budget = 0;
        do begin
            step();
            budget++;
        end while (!(busy && !m_tx_axis_tvalid) && budget < 20);
        check("reach_gap", 64'(busy && !m_tx_axis_tvalid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_sent", 64'(sent_count), 64'd0);
        check("arst_seq", 64'(m_tx_seq), 64'd0);
        check("arst_ts", m_tx_axis_ts, 64'd0);
        check("arst_tvalid", 64'(m_tx_axis_tvalid), 64'd0);
        enable = 1'b0;
        m_tx_axis_tready = 1'b0;
        gap_track = 0;
        #1 rst = 1'b0;
        step();
        check("post_rst_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
